// File: rtl/tune_cmd_pkg.sv
// rtl/tune_cmd_pkg.sv - shared constants and state encoding for the tuning command responder
//
// Purpose: frame byte values, command codes, payload length and the FSM
// state type shared by tune_cmd_rx and its testbench-visible behaviour.
package tune_cmd_pkg;

  localparam logic [7:0] SYNC_BYTE      = 8'hA5;
  localparam logic [7:0] ACK_BYTE       = 8'h06;
  localparam logic [7:0] NAK_BYTE       = 8'h15;

  localparam logic [7:0] CMD_SET_PHASE  = 8'h01;
  localparam logic [7:0] CMD_SET_DECIM  = 8'h02;
  localparam logic [7:0] CMD_READ_PHASE = 8'h03;

  localparam int PAYLOAD_BYTES = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GET_CMD,
    ST_GET_PAY,
    ST_GET_CSUM,
    ST_EXEC,
    ST_TX_WAIT,
    ST_TX_SEND
  } state_e;

  // States in which a frame is partially received and the inter-byte
  // timeout must be running.
  function automatic logic is_rx_state(input state_e s);
    return (s == ST_GET_CMD) || (s == ST_GET_PAY) || (s == ST_GET_CSUM);
  endfunction

endpackage

// File: rtl/tune_cmd_rx_byte_timeout_ctr.sv
// rtl/tune_cmd_rx_byte_timeout_ctr.sv - restartable inter-byte timeout down-counter
//
// Purpose: counts clk cycles since the last received byte while enabled and
// flags expiry after TIMEOUT_CLKS cycles without a restart.
// Ports:
//   clk       in   rising-edge clock
//   rst_n     in   synchronous active-low reset
//   i_en      in   counter runs only while high; reloads while low
//   i_restart in   reload the counter (a byte arrived)
//   o_expire  out  high while enabled and the count has run out
module byte_timeout_ctr #(
  parameter int unsigned TIMEOUT_CLKS = 133000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_en,
  input  logic i_restart,
  output logic o_expire
);

  localparam int unsigned CW = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [CW-1:0] LOAD = CW'(TIMEOUT_CLKS - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!i_en || i_restart) begin
      cnt_d = LOAD;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= LOAD;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Expiry ignores i_restart, so a byte landing on the expiry cycle loses.
  assign o_expire = i_en && (cnt_q == '0);

endmodule

// File: rtl/tune_cmd_rx.sv
// rtl/tune_cmd_rx.sv - framed UART command responder for NCO tuning word and CIC decimation
//
// Purpose: parses SYNC/CMD/8-byte payload/CSUM frames from uart_rx, updates
// the NCO phase increment or CIC decimation ratio, and replies ACK/NAK (plus
// readback data) through the uart_tx strobe handshake.
// Ports:
//   clk          in   osc_clk, rising edge
//   rst_n        in   synchronous active-low reset
//   i_rx_dv      in   one-cycle valid strobe from uart_rx
//   i_rx_byte    in   received byte
//   i_tx_active  in   uart_tx busy
//   o_tx_dv      out  one-cycle strobe to uart_tx
//   o_tx_byte    out  byte to send, held until the next strobe
//   o_phase_inc  out  NCO phase increment
//   o_decim      out  CIC decimation ratio
//   o_update     out  one-cycle pulse coinciding with a new register value
//   o_busy       out  high whenever a frame or reply is in progress
module tune_cmd_rx
  import tune_cmd_pkg::*;
#(
  parameter logic [63:0] DEFAULT_PHASE_INC = 64'd138697310208,
  parameter logic [15:0] DEFAULT_DECIM     = 16'd2048,
  parameter int unsigned TIMEOUT_CLKS      = 133000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_rx_dv,
  input  logic [7:0]  i_rx_byte,
  input  logic        i_tx_active,
  output logic        o_tx_dv,
  output logic [7:0]  o_tx_byte,
  output logic [63:0] o_phase_inc,
  output logic [15:0] o_decim,
  output logic        o_update,
  output logic        o_busy
);

  localparam logic [2:0] LAST_PAY_IDX = 3'(PAYLOAD_BYTES - 1);

  state_e       state_q, state_d;
  logic [7:0]   cmd_q, cmd_d;
  logic [7:0]   csum_q, csum_d;
  logic [2:0]   idx_q, idx_d;
  logic [63:0]  shreg_q, shreg_d;
  logic         csum_ok_q, csum_ok_d;
  logic [63:0]  phase_q, phase_d;
  logic [15:0]  decim_q, decim_d;
  logic         update_q, update_d;
  logic         tx_dv_q, tx_dv_d;
  logic [7:0]   tx_byte_q, tx_byte_d;
  logic [71:0]  reply_q, reply_d;
  logic [3:0]   tx_left_q, tx_left_d;
  logic         tx_skip_q, tx_skip_d;

  logic         expire;
  logic         cmd_known;

  byte_timeout_ctr #(
    .TIMEOUT_CLKS(TIMEOUT_CLKS)
  ) u_timeout (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_en      (is_rx_state(state_q)),
    .i_restart (i_rx_dv),
    .o_expire  (expire)
  );

  assign cmd_known = (cmd_q == CMD_SET_PHASE) || (cmd_q == CMD_SET_DECIM) ||
                     (cmd_q == CMD_READ_PHASE);

  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    csum_d    = csum_q;
    idx_d     = idx_q;
    shreg_d   = shreg_q;
    csum_ok_d = csum_ok_q;
    phase_d   = phase_q;
    decim_d   = decim_q;
    update_d  = 1'b0;
    tx_dv_d   = 1'b0;
    tx_byte_d = tx_byte_q;
    reply_d   = reply_q;
    tx_left_d = tx_left_q;
    tx_skip_d = tx_skip_q;

    case (state_q)
      ST_IDLE: begin
        if (i_rx_dv && (i_rx_byte == SYNC_BYTE)) begin
          state_d = ST_GET_CMD;
        end
      end

      ST_GET_CMD: begin
        if (expire) begin
          state_d = ST_IDLE;
        end else if (i_rx_dv) begin
          cmd_d   = i_rx_byte;
          csum_d  = i_rx_byte;
          idx_d   = '0;
          state_d = ST_GET_PAY;
        end
      end

      ST_GET_PAY: begin
        if (expire) begin
          state_d = ST_IDLE;
        end else if (i_rx_dv) begin
          // Big-endian payload: first byte ends up in the top octet.
          shreg_d = {shreg_q[55:0], i_rx_byte};
          csum_d  = csum_q ^ i_rx_byte;
          idx_d   = idx_q + 3'd1;
          if (idx_q == LAST_PAY_IDX) begin
            state_d = ST_GET_CSUM;
          end
        end
      end

      ST_GET_CSUM: begin
        if (expire) begin
          state_d = ST_IDLE;
        end else if (i_rx_dv) begin
          csum_ok_d = (i_rx_byte == csum_q);
          state_d   = ST_EXEC;
        end
      end

      ST_EXEC: begin
        tx_skip_d = 1'b0;
        tx_left_d = 4'd1;
        reply_d   = {NAK_BYTE, 64'h0};
        if (csum_ok_q && cmd_known) begin
          reply_d = {ACK_BYTE, 64'h0};
          if (cmd_q == CMD_SET_PHASE) begin
            phase_d  = shreg_q;
            update_d = 1'b1;
          end else if (cmd_q == CMD_SET_DECIM) begin
            decim_d  = shreg_q[15:0];
            update_d = 1'b1;
          end else begin
            reply_d   = {ACK_BYTE, phase_q};
            tx_left_d = 4'd9;
          end
        end
        state_d = ST_TX_WAIT;
      end

      ST_TX_WAIT: begin
        // uart_tx raises its busy flag a cycle after our strobe, so the
        // first cycle after each strobe cannot trust i_tx_active.
        if (tx_skip_q) begin
          tx_skip_d = 1'b0;
        end else if (!i_tx_active) begin
          tx_byte_d = reply_q[71:64];
          reply_d   = {reply_q[63:0], 8'h00};
          tx_left_d = tx_left_q - 4'd1;
          tx_dv_d   = 1'b1;
          state_d   = ST_TX_SEND;
        end
      end

      ST_TX_SEND: begin
        if (tx_left_q != 4'd0) begin
          tx_skip_d = 1'b1;
          state_d   = ST_TX_WAIT;
        end else begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cmd_q     <= '0;
      csum_q    <= '0;
      idx_q     <= '0;
      shreg_q   <= '0;
      csum_ok_q <= 1'b0;
      phase_q   <= DEFAULT_PHASE_INC;
      decim_q   <= DEFAULT_DECIM;
      update_q  <= 1'b0;
      tx_dv_q   <= 1'b0;
      tx_byte_q <= '0;
      reply_q   <= '0;
      tx_left_q <= '0;
      tx_skip_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cmd_q     <= cmd_d;
      csum_q    <= csum_d;
      idx_q     <= idx_d;
      shreg_q   <= shreg_d;
      csum_ok_q <= csum_ok_d;
      phase_q   <= phase_d;
      decim_q   <= decim_d;
      update_q  <= update_d;
      tx_dv_q   <= tx_dv_d;
      tx_byte_q <= tx_byte_d;
      reply_q   <= reply_d;
      tx_left_q <= tx_left_d;
      tx_skip_q <= tx_skip_d;
    end
  end

  assign o_tx_dv     = tx_dv_q;
  assign o_tx_byte   = tx_byte_q;
  assign o_phase_inc = phase_q;
  assign o_decim     = decim_q;
  assign o_update    = update_q;
  assign o_busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_tune_cmd_rx.sv
// tb/tb_tune_cmd_rx.sv - self-checking bench for tune_cmd_rx
module tb_tune_cmd_rx;

  localparam int unsigned TC = 300;
  localparam logic [63:0] DEF_PHASE = 64'd138697310208;
  localparam logic [15:0] DEF_DECIM = 16'd2048;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rx_dv;
  logic [7:0]  rx_byte;
  logic        tx_active = 1'b0;
  logic        tx_dv;
  logic [7:0]  tx_byte;
  logic [63:0] phase_inc;
  logic [15:0] decim;
  logic        update;
  logic        busy;

  int n_vec = 0;
  int n_err = 0;
  int upd_cnt = 0;
  int act_left = 0;

  logic [63:0] phase_m;
  logic [15:0] decim_m;
  logic [7:0]  got_q[$];
  logic [7:0]  exp_q[$];

  tune_cmd_rx #(
    .DEFAULT_PHASE_INC(DEF_PHASE),
    .DEFAULT_DECIM    (DEF_DECIM),
    .TIMEOUT_CLKS     (TC)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_rx_dv     (rx_dv),
    .i_rx_byte   (rx_byte),
    .i_tx_active (tx_active),
    .o_tx_dv     (tx_dv),
    .o_tx_byte   (tx_byte),
    .o_phase_inc (phase_inc),
    .o_decim     (decim),
    .o_update    (update),
    .o_busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // uart_tx stand-in: busy from the cycle after a strobe for a random span.
  always @(posedge clk) begin
    if (tx_dv) begin
      tx_active <= 1'b1;
      act_left  <= int'($urandom_range(2, 8));
    end else if (act_left > 1) begin
      act_left <= act_left - 1;
    end else begin
      tx_active <= 1'b0;
      act_left  <= 0;
    end
  end

  always @(negedge clk) begin
    if (tx_dv) begin
      check("tx_dv_while_active", 64'(tx_active), 64'(1'b0));
      got_q.push_back(tx_byte);
    end
    if (update) upd_cnt++;
  end

  function automatic logic [7:0] csum_of(input logic [7:0] cmd, input logic [63:0] pay);
    logic [7:0] c;
    c = cmd;
    for (int i = 0; i < 8; i++) c = c ^ pay[63-8*i -: 8];
    return c;
  endfunction

  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_dv = 1'b1;
    rx_byte = b;
    @(posedge clk); #1;
    rx_dv = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
  endtask

  task automatic wait_reply(input string tag);
    int n;
    n = 0;
    while (busy && n < 3000) begin @(posedge clk); #1; n++; end
    check({tag, "_idle"}, 64'(busy), 64'(1'b0));
    check({tag, "_reply_len"}, 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      if (i < got_q.size()) check({tag, "_reply_byte"}, 64'(got_q[i]), 64'(exp_q[i]));
  endtask

  task automatic run_frame(input logic [7:0] cmd, input logic [63:0] pay,
                           input logic [7:0] cs, input string tag);
    bit ok, upd;
    int u0;
    ok = (cs == csum_of(cmd, pay));
    upd = 1'b0;
    exp_q.delete();
    got_q.delete();
    if (ok && cmd == 8'h01) begin
      phase_m = pay; upd = 1'b1; exp_q.push_back(8'h06);
    end else if (ok && cmd == 8'h02) begin
      decim_m = pay[15:0]; upd = 1'b1; exp_q.push_back(8'h06);
    end else if (ok && cmd == 8'h03) begin
      exp_q.push_back(8'h06);
      for (int i = 0; i < 8; i++) exp_q.push_back(phase_m[63-8*i -: 8]);
    end else begin
      exp_q.push_back(8'h15);
    end
    u0 = upd_cnt;
    send_byte(8'hA5, int'($urandom_range(0, 3)));
    send_byte(cmd, int'($urandom_range(0, 3)));
    for (int i = 0; i < 8; i++) send_byte(pay[63-8*i -: 8], int'($urandom_range(0, 3)));
    send_byte(cs, 0);
    check({tag, "_upd_early"}, 64'(update), 64'(1'b0));
    @(posedge clk); #1;
    check({tag, "_upd"}, 64'(update), 64'(upd));
    check({tag, "_phase"}, phase_inc, phase_m);
    check({tag, "_decim"}, 64'(decim), 64'(decim_m));
    @(posedge clk); #1;
    check({tag, "_upd_fall"}, 64'(update), 64'(1'b0));
    wait_reply(tag);
    check({tag, "_upd_count"}, 64'(upd_cnt - u0), 64'(upd));
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_tx_dv"}, 64'(tx_dv), 64'(1'b0));
    check({tag, "_tx_byte"}, 64'(tx_byte), 64'(8'h00));
    check({tag, "_update"}, 64'(update), 64'(1'b0));
    check({tag, "_busy"}, 64'(busy), 64'(1'b0));
    check({tag, "_phase"}, phase_inc, DEF_PHASE);
    check({tag, "_decim"}, 64'(decim), 64'(DEF_DECIM));
  endtask

  initial begin
    logic [7:0]  cmd, cs;
    logic [63:0] pay;
    int n;

    rst_n = 1'b0;
    rx_dv = 1'b0;
    rx_byte = 8'h00;
    phase_m = DEF_PHASE;
    decim_m = DEF_DECIM;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("por");
    rst_n = 1'b1;
    repeat (2) begin @(posedge clk); #1; end

    // Directed frames
    run_frame(8'h01, 64'h1122334455667788, 8'h89, "set_phase");
    run_frame(8'h02, 64'h0000000000000400, 8'h06, "set_decim");
    run_frame(8'h01, 64'h1122334455667788, 8'h88, "bad_csum");
    run_frame(8'h02, 64'h0, 8'h02, "decim_zero");

    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    phase_m = DEF_PHASE;
    decim_m = DEF_DECIM;
    run_frame(8'h03, 64'h0, 8'h03, "read_default");

    // Timeout after a partial frame, boundary on both sides of expiry
    got_q.delete();
    send_byte(8'hA5, 0);
    send_byte(8'h01, 0);
    send_byte(8'h11, 1);
    send_byte(8'h22, 0);
    repeat (TC - 1) begin @(posedge clk); #1; end
    check("tmo_still_busy", 64'(busy), 64'(1'b1));
    @(posedge clk); #1;
    check("tmo_idle", 64'(busy), 64'(1'b0));
    repeat (20) begin @(posedge clk); #1; end
    check("tmo_no_reply", 64'(got_q.size()), 64'd0);
    check("tmo_phase", phase_inc, phase_m);
    run_frame(8'h01, 64'hCAFEF00D12345678, csum_of(8'h01, 64'hCAFEF00D12345678), "after_tmo");

    // Reset during the 5th payload byte
    send_byte(8'hA5, 0);
    send_byte(8'h01, 0);
    for (int i = 0; i < 4; i++) send_byte(8'h10 + 8'(i), 0);
    rx_dv = 1'b1;
    rx_byte = 8'h55;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rx_dv = 1'b0;
    rst_n = 1'b1;
    phase_m = DEF_PHASE;
    decim_m = DEF_DECIM;
    check_reset_vals("rst_pay");
    run_frame(8'h02, 64'h0000000000001234, csum_of(8'h02, 64'h0000000000001234), "after_rst_pay");

    // Reset while reply byte 3 is being strobed
    got_q.delete();
    send_byte(8'hA5, 0);
    send_byte(8'h03, 0);
    for (int i = 0; i < 8; i++) send_byte(8'h00, 0);
    send_byte(8'h03, 0);
    n = 0;
    while (!(tx_dv && got_q.size() == 2) && n < 2000) begin @(posedge clk); #1; n++; end
    check("rst_tx_reached_byte3", 64'(tx_dv && got_q.size() == 2), 64'd1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    phase_m = DEF_PHASE;
    decim_m = DEF_DECIM;
    check_reset_vals("rst_tx");
    repeat (40) begin @(posedge clk); #1; end
    check("rst_tx_reply_cut", 64'(got_q.size()), 64'd3);
    run_frame(8'h03, 64'h0, 8'h03, "after_rst_tx");

    // Randomized frames with leading junk, unknown commands and bad checksums
    for (int k = 0; k < 25; k++) begin
      if ($urandom_range(0, 2) == 0) send_byte(8'($urandom_range(0, 8'hA4)), 1);
      case ($urandom_range(0, 4))
        0: cmd = 8'h01;
        1: cmd = 8'h02;
        2: cmd = 8'h03;
        default: cmd = 8'($urandom);
      endcase
      pay = {$urandom, $urandom};
      cs = csum_of(cmd, pay);
      if ($urandom_range(0, 3) == 0) cs = cs ^ 8'($urandom_range(1, 255));
      run_frame(cmd, pay, cs, "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/tune_cmd_rx.md
Name: tune_cmd_rx

Overview:
- Host-side command responder behind the UART receiver.
- Parses framed byte commands from uart_rx (o_Rx_DV/o_Rx_Byte) and updates the NCO tuning word and the CIC decimation ratio at runtime.
- Replies with ACK/NAK and readback data through uart_tx's i_Tx_DV/i_Tx_Byte handshake.
- Replaces the constant phase_inc_carr and decimation_ratio assignments in top.

Parameters:
- DEFAULT_PHASE_INC, 64'd138697310208: phase_inc value after reset.
- DEFAULT_DECIM, 16'd2048: decimation_ratio value after reset.
- TIMEOUT_CLKS, 133000: maximum clk cycles between bytes of one frame (1 ms at 133 MHz).

Ports:
- clk  in  1  osc_clk domain; all logic is on its rising edge.
- rst_n  in  1  synchronous, active-low reset.
- i_rx_dv  in  1  one-cycle strobe from uart_rx marking a valid byte.
- i_rx_byte  in  8  received byte, valid while i_rx_dv=1.
- i_tx_active  in  1  uart_tx busy.
- o_tx_dv  out  1  one-cycle strobe to uart_tx.
- o_tx_byte  out  8  byte to send, held stable from the strobe until the next strobe.
- o_phase_inc  out  64  NCO phase increment.
- o_decim  out  16  CIC decimation ratio.
- o_update  out  1  one-cycle pulse when o_phase_inc or o_decim changes.
- o_busy  out  1  high in any state other than IDLE.

Behaviour:
- Frame format: SYNC(0xA5), CMD, P0..P7 (payload, big-endian, P0 is the MSB), CSUM.
  - CSUM = XOR of CMD and P0..P7.
- Commands:
  - 0x01: set phase_inc to the 64-bit payload.
  - 0x02: set decim to payload bits P6:P7; P0..P5 are ignored.
  - 0x03: read back phase_inc; payload is ignored.
- States: IDLE, GET_CMD, GET_PAY, GET_CSUM, EXEC, TX_WAIT, TX_SEND.
  - IDLE: on rx_dv with byte 0xA5, go to GET_CMD. Any other byte is discarded and the state stays IDLE.
  - GET_CMD: latch CMD, seed the checksum accumulator with CMD, clear the payload index, go to GET_PAY.
  - GET_PAY: shift the byte into the 64-bit shift register and XOR it into the accumulator. After the 8th byte, go to GET_CSUM.
  - GET_CSUM: compare the byte to the accumulator, then go to EXEC.
  - EXEC (1 cycle), three outcomes:
    - Checksum good, CMD 0x01 or 0x02: update the register, pulse o_update, queue ACK (0x06).
    - Checksum good, CMD 0x03: queue ACK followed by 8 bytes of o_phase_inc, MSB first.
    - Bad checksum or unknown CMD: registers unchanged, no o_update, queue NAK (0x15).
  - TX_WAIT: wait until i_tx_active=0, then go to TX_SEND.
  - TX_SEND: assert o_tx_dv for exactly 1 cycle with the next queued byte. Return to TX_WAIT if bytes remain, else go to IDLE.
  - Because uart_tx raises i_tx_active one cycle after dv, TX_WAIT ignores i_tx_active for the first cycle after each strobe.
- Timeout:
  - In GET_CMD, GET_PAY and GET_CSUM, a counter resets on every rx_dv.
  - When it reaches TIMEOUT_CLKS-1, return to IDLE silently: no reply, no update.
  - The counter is idle in all other states.
- Bytes arriving in EXEC, TX_WAIT or TX_SEND are dropped. The host must wait for the reply.
- An rx_dv in the same cycle as a timeout expiry: the timeout wins and the byte is dropped.
- Update latency: o_phase_inc, o_decim and o_update change on the clk edge ending EXEC, which is 2 cycles after the CSUM byte's rx_dv. o_update is registered and coincides with the new value.
- o_decim = 0 is accepted and stored as-is; guarding against it is the CIC's responsibility.
- Reset (rst_n=0 at a clk edge), including mid-frame or mid-reply:
  - state=IDLE, o_tx_dv=0, o_tx_byte=0x00, o_update=0, o_busy=0.
  - o_phase_inc=DEFAULT_PHASE_INC, o_decim=DEFAULT_DECIM.
  - Any partial frame or queued reply is discarded.

Decomposition:
- Shared package tune_cmd_pkg holds:
  - SYNC_BYTE, ACK_BYTE, NAK_BYTE.
  - CMD_SET_PHASE, CMD_SET_DECIM, CMD_READ_PHASE.
  - The state encoding.
  - PAYLOAD_BYTES=8.
- One natural sub-module: byte_timeout_ctr, the restartable down-counter with an expiry pulse.

Test Plan:
- A5 01 11 22 33 44 55 66 77 88 89 -> o_phase_inc=0x1122334455667788, o_update pulses once 2 clk after the last byte; reply 0x06.
- A5 02 00 00 00 00 00 00 04 00 06 -> o_decim=1024, o_phase_inc unchanged; reply 0x06.
- A5 01 11 22 33 44 55 66 77 88 88 (bad CSUM) -> no o_update, registers unchanged; reply 0x15.
- After reset, A5 03 00×8 03 -> reply 06 00 00 00 20 4B 01 00 00; each o_tx_dv occurs only while i_tx_active=0.
- A5 01 11 22, then idle for TIMEOUT_CLKS -> returns to IDLE, o_busy=0, no reply. A following full valid frame is accepted.
- rst_n low for 1 cycle during the 5th payload byte or during reply byte 3 -> outputs at reset values, o_tx_dv=0. The next frame works.
